// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and codes for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned SB_REG_AW = 5;
  localparam int unsigned SB_T_W    = 2;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  localparam logic [SB_T_W-1:0] TUSE_NONE = 2'd3;
  localparam logic [SB_T_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [SB_T_W-1:0] TNEW_LW   = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic [SB_REG_AW-1:0] dst;
    logic [SB_T_W-1:0]    tnew;
  } sb_entry_t;

  function automatic logic [SB_T_W-1:0] tnew_dec(logic [SB_T_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One registered scoreboard entry: optional saturating Tnew decrement on load,
// or a bubble load that clears the entry.
module scoreboard_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter bit DECREMENT = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      bubble,
  input  sb_entry_t d,
  output sb_entry_t q
);

  sb_entry_t q_d;

  always_comb begin
    q_d = d;
    if (DECREMENT) q_d.tnew = tnew_dec(d.tnew);
    if (bubble) q_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: E/M/W Tnew tracking, stall and forward selects.
// Define HAZARD_STATS_EN to add the 32-bit stall_count output.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW = SB_REG_AW,
  parameter int unsigned T_W    = SB_T_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [T_W-1:0]    id_tuse_rs,
  input  logic [T_W-1:0]    id_tuse_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_we,
  input  logic [T_W-1:0]    id_tnew,
  output logic              stall,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic [T_W-1:0]    e_tnew,
  output logic [T_W-1:0]    m_tnew
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  sb_entry_t e_in, e_q, m_q, w_q;

  function automatic logic hit(sb_entry_t s, logic [SB_REG_AW-1:0] r);
    return s.valid && (s.dst == r) && (r != '0);
  endfunction

  function automatic logic hazard(sb_entry_t e, sb_entry_t m, sb_entry_t w,
                                  logic [SB_REG_AW-1:0] r, logic [SB_T_W-1:0] t);
    return (hit(e, r) && (e.tnew > t)) || (hit(m, r) && (m.tnew > t)) ||
           (hit(w, r) && (w.tnew > t));
  endfunction

  // Only the youngest match may forward; a not-yet-ready young match blocks older ones.
  function automatic logic [1:0] fwd_sel(sb_entry_t e, sb_entry_t m, sb_entry_t w,
                                         logic [SB_REG_AW-1:0] r);
    if (hit(e, r)) return (e.tnew == '0) ? FWD_E : FWD_GRF;
    if (hit(m, r)) return (m.tnew == '0) ? FWD_M : FWD_GRF;
    if (hit(w, r)) return (w.tnew == '0) ? FWD_W : FWD_GRF;
    return FWD_GRF;
  endfunction

  always_comb begin
    e_in.valid = id_we && (id_dst != '0);
    e_in.dst   = id_dst;
    e_in.tnew  = id_tnew;
  end

  scoreboard_entry #(
    .DECREMENT (1'b0)
  ) u_entry_e (
    .clk    (clk),
    .reset  (reset),
    .bubble (stall),
    .d      (e_in),
    .q      (e_q)
  );

  scoreboard_entry #(
    .DECREMENT (1'b1)
  ) u_entry_m (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (e_q),
    .q      (m_q)
  );

  scoreboard_entry #(
    .DECREMENT (1'b1)
  ) u_entry_w (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (m_q),
    .q      (w_q)
  );

  always_comb begin
    stall      = hazard(e_q, m_q, w_q, id_rs, id_tuse_rs) ||
                 hazard(e_q, m_q, w_q, id_rt, id_tuse_rt);
    fwd_rs_sel = fwd_sel(e_q, m_q, w_q, id_rs);
    fwd_rt_sel = fwd_sel(e_q, m_q, w_q, id_rt);
    e_tnew     = e_q.tnew;
    m_tnew     = m_q.tnew;
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, id_dst;
  logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew;
  logic       id_we;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel, e_tnew, m_tnew;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_tuse_rs (id_tuse_rs),
    .id_tuse_rt (id_tuse_rt),
    .id_dst     (id_dst),
    .id_we      (id_we),
    .id_tnew    (id_tnew),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .e_tnew     (e_tnew),
    .m_tnew     (m_tnew)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic [1:0] trs, trt;
    logic [4:0] dst;
    logic       we;
    logic [1:0] tnew;
    logic       x_stall;
    logic [1:0] x_rs, x_rt, x_et, x_mt;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] trs,
                       input logic [1:0] trt, input logic [4:0] dst, input logic we,
                       input logic [1:0] tnew);
    id_rs = rs; id_rt = rt; id_tuse_rs = trs; id_tuse_rt = trt;
    id_dst = dst; id_we = we; id_tnew = tnew;
  endtask

  task automatic check_outs(input string name, input logic s, input logic [1:0] rs_sel,
                            input logic [1:0] rt_sel, input logic [1:0] et,
                            input logic [1:0] mt);
    check({name, ".stall"}, int'(stall), int'(s));
    check({name, ".rs_sel"}, int'(fwd_rs_sel), int'(rs_sel));
    check({name, ".rt_sel"}, int'(fwd_rt_sel), int'(rt_sel));
    check({name, ".e_tnew"}, int'(e_tnew), int'(et));
    check({name, ".m_tnew"}, int'(m_tnew), int'(mt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            name         rs  rt trs trt dst we tn | st rs rt et mt
    vecs[0]  = '{"nop",        0,  0, 3, 3,  0, 0, 0,   0, 0, 0, 0, 0};
    vecs[1]  = '{"lw8",        29, 0, 1, 3,  8, 1, 2,   0, 0, 0, 0, 0};
    vecs[2]  = '{"lwuse_stall", 8, 8, 1, 1,  9, 1, 1,   1, 0, 0, 2, 0};
    vecs[3]  = '{"lwuse_go",    8, 8, 1, 1,  9, 1, 1,   0, 0, 0, 0, 1};
    vecs[4]  = '{"w_fwd_e_stall", 8, 9, 0, 0, 10, 1, 1, 1, 3, 0, 1, 0};
    vecs[5]  = '{"m_fwd_rt",    8, 9, 0, 0, 10, 1, 1,   0, 0, 2, 0, 0};
    vecs[6]  = '{"addu8",       0, 0, 3, 3,  8, 1, 1,   0, 0, 0, 1, 0};
    vecs[7]  = '{"alu_stall",   8, 10, 0, 0, 11, 1, 1,  1, 0, 2, 1, 0};
    vecs[8]  = '{"alu_m_fwd",   8, 10, 0, 0, 11, 1, 1,  0, 2, 3, 0, 0};
    vecs[9]  = '{"dst8_t0",    11, 0, 2, 3,  8, 1, 0,   0, 0, 0, 1, 0};
    vecs[10] = '{"e_wins",      8, 11, 0, 0, 8, 1, 1,   0, 1, 2, 0, 0};
    vecs[11] = '{"e_young",     8, 8, 1, 3,  0, 1, 0,   0, 0, 0, 1, 0};
    vecs[12] = '{"reg0",        0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0};
    vecs[13] = '{"lw5",         0, 8, 3, 0,  5, 1, 2,   0, 0, 3, 0, 0};
    vecs[14] = '{"tuse3",       5, 5, 3, 2,  0, 0, 0,   0, 0, 0, 2, 0};
    vecs[15] = '{"m_stall",     5, 0, 0, 3,  0, 0, 0,   1, 0, 0, 0, 1};
    vecs[16] = '{"w_fwd",       5, 0, 0, 3,  0, 0, 0,   0, 3, 0, 0, 0};

    reset = 1'b0;
    drive(5'd8, 5'd8, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    #2;
    check_outs("reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    #10 reset = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].trs, vecs[i].trt, vecs[i].dst, vecs[i].we,
            vecs[i].tnew);
      #1;
      check_outs(vecs[i].name, vecs[i].x_stall, vecs[i].x_rs, vecs[i].x_rt, vecs[i].x_et,
                 vecs[i].x_mt);
      tick();
    end

    // Reset during a load-use stall must clear everything without a clock edge.
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 1'b1, 2'd2);
    #1;
    tick();
    drive(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0);
    #1;
    check("rst_pre.stall", int'(stall), 1);
    #1 reset = 1'b0;
    #1;
    check("rst_async.stall", int'(stall), 0);
    check("rst_async.e_tnew", int'(e_tnew), 0);
    tick();
    reset = 1'b1;
    #2;
    check("rst_rel.stall", int'(stall), 0);
    check("rst_rel.rs_sel", int'(fwd_rs_sel), 0);
    tick();
    check("rst_rel.m_tnew", int'(m_tnew), 0);
    check("rst_rel2.stall", int'(stall), 0);

`ifdef HAZARD_STATS_EN
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("cnt_clear", int'(stall_count), 0);
    for (int p = 0; p < 3; p++) begin
      drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 1'b1, 2'd2);
      tick();
      drive(5'd8, 5'd0, 2'd1, 2'd3, 5'd0, 1'b0, 2'd0);
      tick();
      tick();
    end
    check("cnt_three", int'(stall_count), 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
